checker_turn_ctrl: RTL and testbench

Turn sequencer for the checkers game. It takes the player's cursor and select-button pulses, reads squares through a one-cycle board read port, and checks that the chosen source and destination form a legal simple move or a single jump. It then issues exactly one move command per turn to the board-update logic over a req/ack handshake, tracks whose turn it is and the remaining piece counts, and flags the winner.

---
 rtl/checker_turn_ctrl_pkg.sv | 39 +++
 rtl/checker_turn_ctrl_if.sv | 42 ++++
 rtl/checker_turn_ctrl_move_geom.sv | 41 ++++
 rtl/checker_turn_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_checker_turn_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/checker_turn_ctrl_pkg.sv
// Shared definitions for the checkers turn sequencer: square field layout,
// FSM state encoding, piece-count width and board edge rows.
package checker_turn_ctrl_pkg;

  // Bit positions inside a square word returned by the board read port.
  localparam int OCC  = 2;
  localparam int RED  = 1;
  localparam int KING = 0;

  localparam int CNT_W = 4;

  localparam logic [2:0] EDGE_LO = 3'd0;
  localparam logic [2:0] EDGE_HI = 3'd7;

  // Square address is {x[2:0], y[2:0]}.
  typedef logic [5:0] loc_t;

  typedef enum logic [3:0] {
    SEL_WAIT,
    SRC_RD,
    SRC_CHK,
    HELD,
    DST_RD,
    DST_CHK,
    MID_RD,
    MID_CHK,
    ISSUE,
    DONE
  } state_e;

  function automatic logic [2:0] loc_x(input loc_t l);
    return l[5:3];
  endfunction

  function automatic logic [2:0] loc_y(input loc_t l);
    return l[2:0];
  endfunction

endpackage

// File: rtl/checker_turn_ctrl_if.sv
// Player input, board read port, move command handshake and game status
// bundled between the turn sequencer and its environment.
interface checker_turn_ctrl_if;
  import checker_turn_ctrl_pkg::*;

  logic [5:0]       cursor_loc;
  logic             btn_sel;
  logic [5:0]       rd_addr;
  logic [2:0]       rd_data;
  logic [5:0]       sel_loc;
  logic             sel_valid;
  logic             mv_req;
  logic             mv_ack;
  logic [5:0]       mv_from;
  logic [5:0]       mv_to;
  logic             mv_cap;
  logic [5:0]       mv_cap_loc;
  logic             mv_promote;
  logic             turn;
  logic             err;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] white_cnt;
  logic             game_over;
  logic             winner;

  // Sequencer side.
  modport slave (
    input  cursor_loc, btn_sel, rd_data, mv_ack,
    output rd_addr, sel_loc, sel_valid, mv_req, mv_from, mv_to, mv_cap,
           mv_cap_loc, mv_promote, turn, err, red_cnt, white_cnt,
           game_over, winner
  );

  // Environment side: player, board RAM and board writer.
  modport master (
    output cursor_loc, btn_sel, rd_data, mv_ack,
    input  rd_addr, sel_loc, sel_valid, mv_req, mv_from, mv_to, mv_cap,
           mv_cap_loc, mv_promote, turn, err, red_cnt, white_cnt,
           game_over, winner
  );

endinterface

// File: rtl/checker_turn_ctrl_move_geom.sv
// Combinational move geometry: diagonal shape/direction legality, jump
// detection, jumped-over square and promotion for a source/destination pair.
module move_geom
  import checker_turn_ctrl_pkg::*;
(
  input  loc_t src_i,
  input  loc_t dst_i,
  input  logic red_i,
  input  logic king_i,
  output logic legal_shape_o,
  output logic is_jump_o,
  output loc_t mid_loc_o,
  output logic promote_o
);

  logic signed [3:0] dx;
  logic signed [3:0] dy;
  logic [3:0]        adx;
  logic [3:0]        ady;
  logic              fwd;
  logic [3:0]        sum_x;
  logic [3:0]        sum_y;

  // Signed deltas, magnitudes, direction and midpoint.
  always_comb begin
    dx  = $signed({1'b0, loc_x(dst_i)}) - $signed({1'b0, loc_x(src_i)});
    dy  = $signed({1'b0, loc_y(dst_i)}) - $signed({1'b0, loc_y(src_i)});
    adx = dx[3] ? 4'(-dx) : dx;
    ady = dy[3] ? 4'(-dy) : dy;
    // Red advances toward y = 7, white toward y = 0; kings go either way.
    fwd = king_i || (red_i ? (!dy[3] && (dy != 4'sd0)) : dy[3]);
    legal_shape_o = (adx == ady) && ((adx == 4'd1) || (adx == 4'd2)) && fwd;
    is_jump_o     = (adx == 4'd2);
    sum_x         = {1'b0, loc_x(src_i)} + {1'b0, loc_x(dst_i)};
    sum_y         = {1'b0, loc_y(src_i)} + {1'b0, loc_y(dst_i)};
    mid_loc_o     = {sum_x[3:1], sum_y[3:1]};
    promote_o     = !king_i && (( red_i && (loc_y(dst_i) == EDGE_HI)) ||
                                (!red_i && (loc_y(dst_i) == EDGE_LO)));
  end

endmodule

// File: rtl/checker_turn_ctrl.sv
// Checkers turn sequencer: validates a source/destination selection against
// the board, issues one move command per turn over req/ack, and keeps the
// turn, piece counts and winner.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SEL_WAIT | waiting for the player to pick a source square
// SRC_RD   | board read of the candidate source in flight
// SRC_CHK  | source contents valid; accept own piece or flag err
// HELD     | piece held; wait for destination or deselect
// DST_RD   | board read of the destination in flight
// DST_CHK  | destination contents valid; check emptiness and geometry
// MID_RD   | board read of the jumped-over square in flight
// MID_CHK  | jumped-over square must hold an opponent piece
// ISSUE    | mv_req held with stable payload until mv_ack
// DONE     | flip turn, detect game end (sticky once ended)
module checker_turn_ctrl
  import checker_turn_ctrl_pkg::*;
#(
  parameter int START_PIECES = 12,
  parameter bit RED_FIRST    = 1'b1
)(
  input  logic          clk,
  input  logic          rst,
  checker_turn_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PIECES);

  state_e           state_q, state_d;
  loc_t             rd_addr_q, rd_addr_d;
  loc_t             dst_q, dst_d;
  logic             src_king_q, src_king_d;
  loc_t             sel_loc_q, sel_loc_d;
  logic             sel_valid_q, sel_valid_d;
  logic             mv_req_q, mv_req_d;
  loc_t             mv_from_q, mv_from_d;
  loc_t             mv_to_q, mv_to_d;
  logic             mv_cap_q, mv_cap_d;
  loc_t             mv_cap_loc_q, mv_cap_loc_d;
  logic             mv_promote_q, mv_promote_d;
  logic             turn_q, turn_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d;
  logic [CNT_W-1:0] white_cnt_q, white_cnt_d;
  logic             game_over_q, game_over_d;
  logic             winner_q, winner_d;

  logic             geom_legal;
  logic             geom_jump;
  loc_t             geom_mid;
  logic             geom_promote;

  // The held piece always belongs to the side to move, so turn is its colour.
  move_geom u_geom (
    .src_i         (sel_loc_q),
    .dst_i         (dst_q),
    .red_i         (turn_q),
    .king_i        (src_king_q),
    .legal_shape_o (geom_legal),
    .is_jump_o     (geom_jump),
    .mid_loc_o     (geom_mid),
    .promote_o     (geom_promote)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEL_WAIT;
      rd_addr_q    <= '0;
      dst_q        <= '0;
      src_king_q   <= 1'b0;
      sel_loc_q    <= '0;
      sel_valid_q  <= 1'b0;
      mv_req_q     <= 1'b0;
      mv_from_q    <= '0;
      mv_to_q      <= '0;
      mv_cap_q     <= 1'b0;
      mv_cap_loc_q <= '0;
      mv_promote_q <= 1'b0;
      turn_q       <= RED_FIRST;
      err_q        <= 1'b0;
      red_cnt_q    <= START_CNT;
      white_cnt_q  <= START_CNT;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      dst_q        <= dst_d;
      src_king_q   <= src_king_d;
      sel_loc_q    <= sel_loc_d;
      sel_valid_q  <= sel_valid_d;
      mv_req_q     <= mv_req_d;
      mv_from_q    <= mv_from_d;
      mv_to_q      <= mv_to_d;
      mv_cap_q     <= mv_cap_d;
      mv_cap_loc_q <= mv_cap_loc_d;
      mv_promote_q <= mv_promote_d;
      turn_q       <= turn_d;
      err_q        <= err_d;
      red_cnt_q    <= red_cnt_d;
      white_cnt_q  <= white_cnt_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    dst_d        = dst_q;
    src_king_d   = src_king_q;
    sel_loc_d    = sel_loc_q;
    sel_valid_d  = sel_valid_q;
    mv_req_d     = mv_req_q;
    mv_from_d    = mv_from_q;
    mv_to_d      = mv_to_q;
    mv_cap_d     = mv_cap_q;
    mv_cap_loc_d = mv_cap_loc_q;
    mv_promote_d = mv_promote_q;
    turn_d       = turn_q;
    err_d        = 1'b0;
    red_cnt_d    = red_cnt_q;
    white_cnt_d  = white_cnt_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;

    unique case (state_q)
      SEL_WAIT: begin
        // rd_addr doubles as the latched source candidate.
        if (bus.btn_sel) begin
          rd_addr_d = bus.cursor_loc;
          state_d   = SRC_RD;
        end
      end

      SRC_RD: state_d = SRC_CHK;

      SRC_CHK: begin
        if (bus.rd_data[OCC] && (bus.rd_data[RED] == turn_q)) begin
          sel_loc_d   = rd_addr_q;
          sel_valid_d = 1'b1;
          src_king_d  = bus.rd_data[KING];
          state_d     = HELD;
        end else begin
          err_d   = 1'b1;
          state_d = SEL_WAIT;
        end
      end

      HELD: begin
        if (bus.btn_sel) begin
          if (bus.cursor_loc == sel_loc_q) begin
            sel_valid_d = 1'b0;
            state_d     = SEL_WAIT;
          end else begin
            dst_d     = bus.cursor_loc;
            rd_addr_d = bus.cursor_loc;
            state_d   = DST_RD;
          end
        end
      end

      DST_RD: state_d = DST_CHK;

      DST_CHK: begin
        if (bus.rd_data[OCC] || !geom_legal) begin
          err_d   = 1'b1;
          state_d = HELD;
        end else if (geom_jump) begin
          rd_addr_d = geom_mid;
          state_d   = MID_RD;
        end else begin
          mv_req_d     = 1'b1;
          mv_from_d    = sel_loc_q;
          mv_to_d      = dst_q;
          mv_cap_d     = 1'b0;
          mv_cap_loc_d = '0;
          mv_promote_d = geom_promote;
          state_d      = ISSUE;
        end
      end

      MID_RD: state_d = MID_CHK;

      MID_CHK: begin
        // rd_addr still holds the midpoint issued from DST_CHK.
        if (bus.rd_data[OCC] && (bus.rd_data[RED] != turn_q)) begin
          mv_req_d     = 1'b1;
          mv_from_d    = sel_loc_q;
          mv_to_d      = dst_q;
          mv_cap_d     = 1'b1;
          mv_cap_loc_d = rd_addr_q;
          mv_promote_d = geom_promote;
          state_d      = ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = HELD;
        end
      end

      ISSUE: begin
        if (bus.mv_ack) begin
          mv_req_d    = 1'b0;
          sel_valid_d = 1'b0;
          if (mv_cap_q) begin
            if (turn_q) begin
              white_cnt_d = (white_cnt_q == '0) ? '0 : white_cnt_q - 1'b1;
            end else begin
              red_cnt_d = (red_cnt_q == '0) ? '0 : red_cnt_q - 1'b1;
            end
          end
          state_d = DONE;
        end
      end

      DONE: begin
        // Once the game has ended, DONE is a parking state: no further toggles.
        if (!game_over_q) begin
          turn_d = !turn_q;
          if ((red_cnt_q == '0) || (white_cnt_q == '0)) begin
            game_over_d = 1'b1;
            winner_d    = (white_cnt_q == '0);
          end else begin
            state_d = SEL_WAIT;
          end
        end
      end

      default: state_d = SEL_WAIT;
    endcase
  end

  assign bus.rd_addr    = rd_addr_q;
  assign bus.sel_loc    = sel_loc_q;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.mv_req     = mv_req_q;
  assign bus.mv_from    = mv_from_q;
  assign bus.mv_to      = mv_to_q;
  assign bus.mv_cap     = mv_cap_q;
  assign bus.mv_cap_loc = mv_cap_loc_q;
  assign bus.mv_promote = mv_promote_q;
  assign bus.turn       = turn_q;
  assign bus.err        = err_q;
  assign bus.red_cnt    = red_cnt_q;
  assign bus.white_cnt  = white_cnt_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_checker_turn_ctrl.sv
// Directed bench for checker_turn_ctrl: board RAM model with one-cycle read,
// hand-computed expectations checked with immediate assertions.
module tb_checker_turn_ctrl;
  import checker_turn_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         n_checks = 0;
  int         n_err = 0;
  logic [2:0] board [64];

  checker_turn_ctrl_if bus();

  checker_turn_ctrl #(.START_PIECES(12), .RED_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rd_data <= board[bus.rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [5:0] loc);
    bus.cursor_loc = loc;
    bus.btn_sel    = 1'b1;
    @(negedge clk);
    bus.btn_sel    = 1'b0;
  endtask

  task automatic ack_once();
    bus.mv_ack = 1'b1;
    @(negedge clk);
    bus.mv_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clr_board();
    for (int i = 0; i < 64; i++) board[i] = 3'b000;
  endtask

  // Red (2,4) jumps white (3,5) landing on (4,6).
  task automatic red_jump();
    press(6'd20);
    tick(2);
    press(6'd38);
    tick(4);
    ack_once();
    tick(1);
  endtask

  // White (5,5) steps to (4,4).
  task automatic white_move();
    press(6'd45);
    tick(2);
    press(6'd36);
    tick(2);
    ack_once();
    tick(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cursor_loc = '0;
    bus.btn_sel    = 1'b0;
    bus.mv_ack     = 1'b0;
    clr_board();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;

    // Reset state
    chk("rst_sel_valid", bus.sel_valid, 0);
    chk("rst_mv_req", bus.mv_req, 0);
    chk("rst_turn", bus.turn, 1);
    chk("rst_red_cnt", bus.red_cnt, 12);
    chk("rst_white_cnt", bus.white_cnt, 12);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_winner", bus.winner, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_mv_cap", bus.mv_cap, 0);
    chk("rst_state", dut.state_q, SEL_WAIT);

    // Stray ack with no request
    bus.mv_ack = 1'b1;
    tick(1);
    bus.mv_ack = 1'b0;
    chk("stray_ack_state", dut.state_q, SEL_WAIT);
    chk("stray_ack_req", bus.mv_req, 0);

    // Simple red move (1,1) -> (2,2)
    board[9] = 3'b110;
    press(6'd9);
    tick(1);
    chk("src_latency", bus.sel_valid, 0);
    tick(1);
    chk("src_sel_valid", bus.sel_valid, 1);
    chk("src_sel_loc", bus.sel_loc, 9);
    press(6'd18);
    tick(1);
    chk("simple_req_early", bus.mv_req, 0);
    tick(1);
    chk("simple_req", bus.mv_req, 1);
    chk("simple_from", bus.mv_from, 9);
    chk("simple_to", bus.mv_to, 18);
    chk("simple_cap", bus.mv_cap, 0);
    chk("simple_promote", bus.mv_promote, 0);
    ack_once();
    chk("simple_req_drop", bus.mv_req, 0);
    chk("simple_sel_clr", bus.sel_valid, 0);
    chk("simple_turn_hold", bus.turn, 1);
    tick(1);
    chk("simple_turn", bus.turn, 0);
    chk("simple_state", dut.state_q, SEL_WAIT);
    chk("simple_white_cnt", bus.white_cnt, 12);

    // Red to move selects a white piece at (0,6)
    do_reset();
    clr_board();
    board[6] = 3'b100;
    press(6'd6);
    tick(1);
    chk("wrong_col_err_early", bus.err, 0);
    tick(1);
    chk("wrong_col_err", bus.err, 1);
    chk("wrong_col_sel", bus.sel_valid, 0);
    tick(1);
    chk("wrong_col_err_drop", bus.err, 0);
    chk("wrong_col_state", dut.state_q, SEL_WAIT);

    // Illegal destinations for red non-king at (2,2)
    do_reset();
    clr_board();
    board[18] = 3'b110;
    press(6'd18);
    tick(2);
    chk("held_sel", bus.sel_valid, 1);
    press(6'd9);
    tick(2);
    chk("backward_err", bus.err, 1);
    chk("backward_state", dut.state_q, HELD);
    tick(1);
    chk("backward_err_drop", bus.err, 0);
    press(6'd20);
    tick(2);
    chk("straight_err", bus.err, 1);
    press(6'd36);
    tick(2);
    chk("jump_mid_addr", bus.rd_addr, 27);
    tick(1);
    chk("jump_empty_err_early", bus.err, 0);
    tick(1);
    chk("jump_empty_err", bus.err, 1);
    chk("jump_empty_state", dut.state_q, HELD);
    chk("jump_empty_req", bus.mv_req, 0);
    chk("jump_empty_sel", bus.sel_valid, 1);
    board[27] = 3'b100;
    press(6'd27);
    tick(2);
    chk("dst_occ_err", bus.err, 1);
    chk("dst_occ_state", dut.state_q, HELD);
    press(6'd18);
    tick(1);
    chk("deselect_sel", bus.sel_valid, 0);
    chk("deselect_state", dut.state_q, SEL_WAIT);

    // Red (2,4) jumps white (3,5) to (4,6)
    do_reset();
    clr_board();
    board[20] = 3'b110;
    board[29] = 3'b100;
    press(6'd20);
    tick(2);
    press(6'd38);
    tick(2);
    chk("jump_req_early", bus.mv_req, 0);
    tick(2);
    chk("jump_req", bus.mv_req, 1);
    chk("jump_cap", bus.mv_cap, 1);
    chk("jump_cap_loc", bus.mv_cap_loc, 29);
    chk("jump_from", bus.mv_from, 20);
    chk("jump_to", bus.mv_to, 38);
    chk("jump_promote", bus.mv_promote, 0);
    ack_once();
    chk("jump_white_cnt", bus.white_cnt, 11);
    chk("jump_red_cnt", bus.red_cnt, 12);
    tick(1);
    chk("jump_turn", bus.turn, 0);

    // Promoting jump (2,5) over (3,6) to (4,7), ack held off
    do_reset();
    clr_board();
    board[21] = 3'b110;
    board[30] = 3'b100;
    press(6'd21);
    tick(2);
    press(6'd39);
    tick(4);
    chk("promo_req", bus.mv_req, 1);
    chk("promo_promote", bus.mv_promote, 1);
    chk("promo_cap_loc", bus.mv_cap_loc, 30);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_req", bus.mv_req, 1);
      chk("stall_to", bus.mv_to, 39);
      chk("stall_turn", bus.turn, 1);
    end
    ack_once();
    tick(1);
    chk("promo_white_cnt", bus.white_cnt, 11);
    chk("promo_turn", bus.turn, 0);

    // White (5,5) -> (4,4), reset while the command is pending
    board[45] = 3'b100;
    press(6'd45);
    tick(2);
    chk("white_sel", bus.sel_valid, 1);
    press(6'd36);
    tick(2);
    chk("white_req", bus.mv_req, 1);
    chk("white_promote", bus.mv_promote, 0);
    rst = 1'b1;
    tick(1);
    chk("abort_req", bus.mv_req, 0);
    chk("abort_white_cnt", bus.white_cnt, 12);
    chk("abort_turn", bus.turn, 1);
    chk("abort_sel", bus.sel_valid, 0);
    chk("abort_state", dut.state_q, SEL_WAIT);
    rst = 1'b0;

    // Play red captures down to the last white piece
    do_reset();
    clr_board();
    board[20] = 3'b110;
    board[29] = 3'b100;
    board[45] = 3'b100;
    for (int i = 0; i < 11; i++) begin
      red_jump();
      chk("loop_white_cnt", bus.white_cnt, 32'(11 - i));
      white_move();
    end
    chk("pre_end_turn", bus.turn, 1);
    chk("pre_end_over", bus.game_over, 0);
    red_jump();
    chk("end_white_cnt", bus.white_cnt, 0);
    chk("end_red_cnt", bus.red_cnt, 12);
    chk("end_game_over", bus.game_over, 1);
    chk("end_winner", bus.winner, 1);
    chk("end_turn", bus.turn, 0);
    press(6'd20);
    tick(3);
    press(6'd45);
    tick(3);
    chk("over_state", dut.state_q, DONE);
    chk("over_sel", bus.sel_valid, 0);
    chk("over_err", bus.err, 0);
    chk("over_sticky", bus.game_over, 1);
    chk("over_turn", bus.turn, 0);
    do_reset();
    chk("post_rst_over", bus.game_over, 0);
    chk("post_rst_white", bus.white_cnt, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
